ram_fifo_ctrl: RTL

Initiator/controller for the team's 64x8 single-port RAM (`single_port_ram`, instantiated alongside, not inside). It presents a valid/ready FIFO to upstream and downstream logic, and it drives the RAM's `we`, `wr_addr`, `rd_addr` and `data` and consumes its registered `q`. It arbitrates the single RAM port between writes and reads, tracks pointers and occupancy, and holds the oldest item in an output register.

---
 rtl/ram_fifo_pkg.sv | 31 +++
 rtl/ram_fifo_ctrl_if.sv | 29 ++
 rtl/fifo_ptr_ctr.sv | 38 +++
 rtl/ram_fifo_ctrl.sv | 94 +++++++++
 4 files changed

// File: rtl/ram_fifo_pkg.sv
// Shared widths and types for the RAM-backed FIFO controller and the 64x8 single-port RAM.
package ram_fifo_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    // Encoding keeps rd_pending and out_valid as single, mutually exclusive state bits.
    typedef enum logic [1:0] {
        HEAD_EMPTY = 2'b00,
        HEAD_PEND  = 2'b01,
        HEAD_VALID = 2'b10
    } head_state_e;

    typedef struct packed {
        logic  we;
        addr_t wr_addr;
        addr_t rd_addr;
        data_t data;
    } ram_req_t;

    function automatic cnt_t occ_sum(cnt_t mem_count, logic rd_pending, logic out_valid);
        return cnt_t'(mem_count + CNT_W'(rd_pending) + CNT_W'(out_valid));
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream handshake plus RAM port bundle; master is the environment, slave is the controller.
interface ram_fifo_ctrl_if;
    import ram_fifo_pkg::*;

    data_t in_data;
    logic  in_valid;
    logic  in_ready;
    data_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  ram_we;
    addr_t ram_wr_addr;
    addr_t ram_rd_addr;
    data_t ram_data;
    data_t ram_q;

    modport master (
        output in_data, in_valid, out_ready, ram_q,
        input  in_ready, out_data, out_valid,
        input  ram_we, ram_wr_addr, ram_rd_addr, ram_data
    );

    modport slave (
        input  in_data, in_valid, out_ready, ram_q,
        output in_ready, out_data, out_valid,
        output ram_we, ram_wr_addr, ram_rd_addr, ram_data
    );

endinterface

// File: rtl/fifo_ptr_ctr.sv
// Write/read pointers and RAM-resident item count for the FIFO controller.
module fifo_ptr_ctr
    import ram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  inc_wr,
    input  logic  inc_rd,
    output addr_t wr_ptr,
    output addr_t rd_ptr,
    output cnt_t  mem_count,
    output logic  full,
    output logic  nonzero
);

    // Pointers wrap naturally at DEPTH through ADDR_W overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
        end else begin
            if (inc_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (inc_rd) rd_ptr <= rd_ptr + ADDR_W'(1);
            unique case ({inc_wr, inc_rd})
                2'b10:   mem_count <= mem_count + CNT_W'(1);
                2'b01:   mem_count <= mem_count - CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
        end
    end

    always_comb begin
        full    = (mem_count == CNT_W'(DEPTH));
        nonzero = (mem_count != '0);
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready FIFO over an external single-port RAM; reads win the port, head item lives in a register.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    ram_fifo_ctrl_if.slave        bus,
    output cnt_t                  occupancy,
    output logic                  full,
    output logic                  empty
);

    head_state_e state;
    head_state_e state_nxt;

    addr_t    wr_ptr;
    addr_t    rd_ptr;
    cnt_t     mem_count;
    logic     mem_nonzero;
    logic     rd_issue;
    logic     rd_pending;
    logic     out_valid;
    logic     in_ready;
    logic     wr_en;
    data_t    out_data_q;
    ram_req_t ram_req;

    fifo_ptr_ctr u_ptr (
        .clk       (clk),
        .rst       (rst),
        .inc_wr    (wr_en),
        .inc_rd    (rd_issue),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr),
        .mem_count (mem_count),
        .full      (full),
        .nonzero   (mem_nonzero)
    );

    // Head-of-queue state register.
    always_ff @(posedge clk) begin
        if (rst) state <= HEAD_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HEAD_EMPTY: if (mem_nonzero)   state_nxt = HEAD_PEND;
            HEAD_PEND:                     state_nxt = HEAD_VALID;
            HEAD_VALID: if (bus.out_ready) state_nxt = HEAD_EMPTY;
            default:                       state_nxt = HEAD_EMPTY;
        endcase
    end

    // Read issue uses registered state only; writes yield to it and are blocked during reset.
    always_comb begin
        rd_pending = 1'b0;
        out_valid  = 1'b0;
        rd_issue   = 1'b0;
        in_ready   = 1'b0;
        wr_en      = 1'b0;
        rd_pending = (state == HEAD_PEND);
        out_valid  = (state == HEAD_VALID);
        rd_issue   = (state == HEAD_EMPTY) && mem_nonzero;
        in_ready   = !full && !rd_issue;
        wr_en      = bus.in_valid && in_ready && !rst;
    end

    // Output register captures the RAM's registered q the cycle after issue.
    always_ff @(posedge clk) begin
        if (rst)                    out_data_q <= '0;
        else if (state == HEAD_PEND) out_data_q <= bus.ram_q;
    end

    always_comb begin
        ram_req.we      = wr_en;
        ram_req.wr_addr = wr_ptr;
        ram_req.rd_addr = rd_ptr;
        ram_req.data    = bus.in_data;
    end

    assign bus.ram_we      = ram_req.we;
    assign bus.ram_wr_addr = ram_req.wr_addr;
    assign bus.ram_rd_addr = ram_req.rd_addr;
    assign bus.ram_data    = ram_req.data;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_data    = out_data_q;

    assign occupancy = occ_sum(mem_count, rd_pending, out_valid);
    assign empty     = (occupancy == '0);

endmodule
